// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter driving a shared 4:1 data mux.
// Four level-sensitive requesters compete for one registered output lane.
// Each grant lasts at most MAX_HOLD cycles, or until its request drops if
// MAX_HOLD is 0. All outputs are registered.
// Optional feature: define MUX_ARB_LOCK_EN so that lock=1 keeps the current
// grant past its hold limit. Without the macro, lock is accepted but ignored.
// Handshake: req[i] is a level request sampled only at rising edges. gnt/sel
// and out_vld change one edge after the request is seen. Out is valid exactly
// when out_vld=1. Requesters have no way to stall the block.
// state_dbg exposes the FSM state: 0 = IDLE, 1 = GRANT.

module mux4_rr_arbiter #(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req,
    input  logic [4*DATA_W-1:0] In,
    input  logic                lock,
    output logic [3:0]          gnt,
    output logic [1:0]          sel,
    output logic [DATA_W-1:0]   Out,
    output logic                out_vld,
    output logic                state_dbg
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] sel_n;
    logic [7:0] hold_cnt, hold_n;
    logic [2:0] pick_ptr;
    logic [2:0] pick_next;
    logic       at_limit;
    logic       lock_hold;

`ifdef MUX_ARB_LOCK_EN
    assign lock_hold = lock;
`else
    // lock has no effect in this build
    logic unused_lock;
    assign unused_lock = lock;
    assign lock_hold   = 1'b0;
`endif

    // Returns {found, index}. The search starts at 'start' and wraps mod 4.
    // The loop runs from the farthest offset down to the nearest, so the
    // nearest set bit is the last one written and therefore wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign pick_ptr  = rr_pick(req, ptr);
    assign pick_next = rr_pick(req, sel + 2'd1);
    assign at_limit  = HOLD_EN && (hold_cnt == HOLD_LAST);
    assign state_dbg = state;

    // Next-state arbitration: release, expiry or keep, in priority order
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        hold_n  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_ptr[2]) begin
                    state_n = GRANT;
                    sel_n   = pick_ptr[1:0];
                    hold_n  = 8'd0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    // Owner dropped its request. Hand over on this edge, or go idle.
                    ptr_n = sel + 2'd1;
                    if (pick_next[2]) begin
                        sel_n  = pick_next[1:0];
                        hold_n = 8'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (at_limit && !lock_hold) begin
                    // Burst expired. req[sel] is still set, so a winner always exists.
                    ptr_n  = sel + 2'd1;
                    sel_n  = pick_next[1:0];
                    hold_n = 8'd0;
                end else if (!at_limit) begin
                    // Keep the grant. When locked at the limit, the count saturates.
                    hold_n = hold_cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= 8'd0;
            sel      <= 2'd0;
            gnt      <= 4'd0;
            Out      <= '0;
            out_vld  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            sel      <= sel_n;
            out_vld  <= (state_n == GRANT);
            if (state_n == GRANT) begin
                gnt <= 4'b0001 << sel_n;
                Out <= In[int'(sel_n)*DATA_W +: DATA_W];
            end else begin
                gnt <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed and randomized checks of mux4_rr_arbiter.
// The reference model tracks the current owner and the cycles it has held the
// lane, using integer arithmetic mod 4.

module tb_mux4_rr_arbiter;

    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic [4*DW-1:0] din;
    logic          lock;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] dout;
    logic          out_vld;
    logic          state_dbg;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            m_owner = -1;   // -1 = nobody granted
    int            m_held  = 0;    // cycles the current owner has been shown
    int            m_ptr   = 0;
    logic [DW-1:0] m_out   = '0;

    mux4_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .In        (din),
        .lock      (lock),
        .gnt       (gnt),
        .sel       (sel),
        .Out       (dout),
        .out_vld   (out_vld),
        .state_dbg (state_dbg)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
        m_out   = '0;
    endtask

    // One rising edge of the arbiter, expressed directly in terms of its rules
    task automatic model_edge(input logic [3:0] r, input logic [4*DW-1:0] d, input logic l);
        bit locked;
`ifdef MUX_ARB_LOCK_EN
        locked = l;
`else
        locked = 1'b0;
        if (l) locked = 1'b0;
`endif
        if (m_owner < 0) begin
            m_owner = first_from(r, m_ptr);
            m_held  = 1;
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = first_from(r, m_ptr);
            m_held  = 1;
        end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && !locked) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = first_from(r, m_ptr);
            m_held  = 1;
        end else if (MAX_HOLD == 0 || m_held < MAX_HOLD) begin
            m_held++;
        end
        if (m_owner >= 0) m_out = d[m_owner*DW +: DW];
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check({tag, ".gnt"},     32'(gnt),       32'(eg));
        check({tag, ".out_vld"}, 32'(out_vld),   32'(m_owner >= 0));
        check({tag, ".state"},   32'(state_dbg), 32'(m_owner >= 0));
        check({tag, ".Out"},     32'(dout),      32'(m_out));
        if (m_owner >= 0) check({tag, ".sel"}, 32'(sel), 32'(m_owner));
        check({tag, ".onehot"},  32'($countones(gnt) <= 1), 32'(1));
    endtask

    // Driver: change inputs between edges, take one edge, sample 1 ns after it
    task automatic step(input string tag, input logic [3:0] r, input logic l);
        req  = r;
        lock = l;
        din  = 32'($urandom);
        @(posedge clk);
        model_edge(r, din, l);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'd0;
        lock  = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Asynchronous reset pulse placed between two edges
    task automatic mid_reset(input string tag);
        #3 rst_n = 1'b0;
        req = 4'd0;
        #1;
        model_reset();
        check({tag, ".gnt"},     32'(gnt),     32'(0));
        check({tag, ".sel"},     32'(sel),     32'(0));
        check({tag, ".Out"},     32'(dout),    32'(0));
        check({tag, ".out_vld"}, 32'(out_vld), 32'(0));
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] cur;
        bit reached;
        rst_n = 1'b0;
        req   = 4'hF;
        lock  = 1'b0;
        din   = 32'($urandom);

        // Reset with all requests high: everything stays cleared
        repeat (2) @(posedge clk);
        #1;
        check("reset.gnt",     32'(gnt),     32'(0));
        check("reset.sel",     32'(sel),     32'(0));
        check("reset.Out",     32'(dout),    32'(0));
        check("reset.out_vld", 32'(out_vld), 32'(0));
        rst_n = 1'b1;

        // Release with req=F: requester 0 one edge later, then 4-cycle rotation
        step("release", 4'hF, 1'b0);
        check("release.gnt_const", 32'(gnt), 32'(4'b0001));
        for (int k = 1; k <= 16; k++) begin
            step("rotate", 4'hF, 1'b0);
            check("rotate.sel_const", 32'(sel), 32'((k / 4) % 4));
        end

        // Early release: requester 0 drops, 2 follows with no gap, then idle
        do_reset();
        step("early", 4'b0101, 1'b0);
        step("early", 4'b0101, 1'b0);
        step("early", 4'b0100, 1'b0);
        check("early.sel_const", 32'(sel), 32'(2));
        check("early.vld_const", 32'(out_vld), 32'(1));
        step("early", 4'b0000, 1'b0);
        check("early.idle_vld", 32'(out_vld), 32'(0));
        check("early.idle_gnt", 32'(gnt), 32'(0));

        // Sole requester: re-granted at every expiry, gnt never drops
        for (int k = 0; k < 12; k++) begin
            step("sole", 4'b1000, 1'b0);
            check("sole.gnt_const", 32'(gnt), 32'(4'b1000));
        end

        // lock asserted: only the model's build configuration decides its effect
        do_reset();
        for (int k = 0; k < 10; k++) step("lock", 4'hF, 1'b1);
        step("unlock", 4'hF, 1'b0);

        // Mid-grant reset while requester 2 owns the lane
        do_reset();
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            step("to_sel2", 4'hF, 1'b0);
            if (m_owner == 2) reached = 1'b1;
        end
        check("to_sel2.reached", 32'(reached), 32'(1));
        mid_reset("midrst");
        step("after_rst", 4'b0110, 1'b0);
        check("after_rst.gnt_const", 32'(gnt), 32'(4'b0010));

        // Randomized traffic with occasional async reset pulses
        cur = 4'd0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) cur = 4'($urandom);
            if ($urandom_range(0, 15) == 0) cur = 4'd0;
            step("rand", cur, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 60) == 0) mid_reset("rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
